// File: rtl/ieee2flopoco_cvt.sv
// IEEE-754 binary -> FloPoCo {exn, sign, exp, frac} converter, two-stage valid/ready pipeline.
// Define FCVT_STATS_EN to add saturating NaN / flushed-subnormal input counters.
module ieee2flopoco_cvt #(
  parameter int WE = 8,
  parameter int WF = 23
`ifdef FCVT_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WE+WF:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WE+WF+2:0] out_data
`ifdef FCVT_STATS_EN
  ,
  output logic [CNT_W-1:0] nan_count,
  output logic [CNT_W-1:0] flush_count
`endif
);

  // Handshake: a word moves on any rising edge where its valid and the
  // consumer's ready are both high; each stage advances when empty or when the
  // stage after it advances, so in_ready is purely combinational (no skid).
  logic w_s2_adv;
  logic w_s1_adv;

  logic            w_in_sign;
  logic [WE-1:0]   w_in_exp;
  logic [WF-1:0]   w_in_frac;
  logic            w_in_exp_zero;
  logic            w_in_exp_ones;
  logic            w_in_frac_zero;

  logic            r_s1_valid;
  logic            r_s1_sign;
  logic [WE-1:0]   r_s1_exp;
  logic [WF-1:0]   r_s1_frac;
  logic            r_s1_exp_zero;
  logic            r_s1_exp_ones;
  logic            r_s1_frac_zero;

  logic              r_s2_valid;
  logic [WE+WF+2:0]  r_s2_data;
  logic [1:0]        w_exn;
  logic              w_keep;
  logic [WE+WF+2:0]  w_s2_next;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_in_sign      = in_data[WE+WF];
  assign w_in_exp       = in_data[WE+WF-1:WF];
  assign w_in_frac      = in_data[WF-1:0];
  assign w_in_exp_zero  = ~|w_in_exp;
  assign w_in_exp_ones  = &w_in_exp;
  assign w_in_frac_zero = ~|w_in_frac;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_sign      <= 1'b0;
      r_s1_exp       <= '0;
      r_s1_frac      <= '0;
      r_s1_exp_zero  <= 1'b0;
      r_s1_exp_ones  <= 1'b0;
      r_s1_frac_zero <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign      <= w_in_sign;
        r_s1_exp       <= w_in_exp;
        r_s1_frac      <= w_in_frac;
        r_s1_exp_zero  <= w_in_exp_zero;
        r_s1_exp_ones  <= w_in_exp_ones;
        r_s1_frac_zero <= w_in_frac_zero;
      end
    end
  end

  // Subnormals collapse to zero; inf/NaN drop exponent and payload.
  always_comb begin
    w_exn  = 2'b01;
    w_keep = 1'b1;
    if (r_s1_exp_zero) begin
      w_exn  = 2'b00;
      w_keep = 1'b0;
    end else if (r_s1_exp_ones) begin
      w_exn  = r_s1_frac_zero ? 2'b10 : 2'b11;
      w_keep = 1'b0;
    end
    w_s2_next = {w_exn, r_s1_sign,
                 w_keep ? r_s1_exp  : {WE{1'b0}},
                 w_keep ? r_s1_frac : {WF{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_s2_next;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

`ifdef FCVT_STATS_EN
  logic             w_accept;
  logic [CNT_W-1:0] r_nan_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nan_cnt   <= '0;
      r_flush_cnt <= '0;
    end else if (w_accept) begin
      if (w_in_exp_ones && !w_in_frac_zero && !(&r_nan_cnt)) begin
        r_nan_cnt <= r_nan_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_in_exp_zero && !w_in_frac_zero && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign nan_count   = r_nan_cnt;
  assign flush_count = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ieee2flopoco_cvt.sv
// Directed bench for ieee2flopoco_cvt: reset, classification, latency, stall, mid-stream reset.
// Counter checks are compiled in only when FCVT_STATS_EN is defined.
module tb_ieee2flopoco_cvt;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_data;
`ifdef FCVT_STATS_EN
  logic [15:0] nan_count;
  logic [15:0] flush_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];
  logic        hold_vld = 1'b0;
  logic [33:0] hold_data = '0;

  // clock / reset block
  always #5 clk = ~clk;

  ieee2flopoco_cvt dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef FCVT_STATS_EN
    ,
    .nan_count  (nan_count),
    .flush_count(flush_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // driver: present one word for one edge; report acceptance and in_ready seen
  task automatic drive(input logic v, input logic [31:0] d, input logic [33:0] e,
                       output logic acc, output logic rdy);
    in_valid = v;
    in_data  = d;
    #1;
    rdy = in_ready;
    acc = v && in_ready;
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [33:0] e);
    logic acc;
    logic rdy;
    int   budget;
    budget = 50;
    acc = 1'b0;
    while (!acc && budget > 0) begin
      drive(1'b1, d, e, acc, rdy);
      budget--;
    end
    check("send_accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: checks ordered output and data stability during stall
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld && out_valid) check("stall_hold", {30'd0, out_data}, {30'd0, hold_data});
        if (out_valid && out_ready) begin
          check("out_expected", {63'd0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", {30'd0, out_data}, {30'd0, e});
          end
          hold_vld = 1'b0;
        end else if (out_valid) begin
          hold_vld  = 1'b1;
          hold_data = out_data;
        end else begin
          hold_vld = 1'b0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] words[8];
  logic [33:0] exps[8];

  initial begin
    logic acc;
    logic rdy;
    int   idx;

    words[0] = 32'h3F800000; exps[0] = 34'h1_3F80_0000;
    words[1] = 32'h80000000; exps[1] = 34'h0_8000_0000;
    words[2] = 32'h7F800000; exps[2] = 34'h2_0000_0000;
    words[3] = 32'h7FC00001; exps[3] = 34'h3_0000_0000;
    words[4] = 32'h80000001; exps[4] = 34'h0_8000_0000;
    words[5] = 32'hC0490FDB; exps[5] = 34'h1_C049_0FDB;
    words[6] = 32'h00800000; exps[6] = 34'h1_0080_0000;
    words[7] = 32'hFFFFFFFF; exps[7] = 34'h3_8000_0000;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) cycle();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {30'd0, out_data}, 64'd0);
`ifdef FCVT_STATS_EN
    check("rst_nan_count", {48'd0, nan_count}, 64'd0);
    check("rst_flush_count", {48'd0, flush_count}, 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // latency: registered in S1 at the accept edge, in S2 at the next one
    drive(1'b1, 32'h3F800000, 34'h1_3F80_0000, acc, rdy);
    check("lat_accept", {63'd0, acc}, 64'd1);
    check("lat_after_accept_valid", {63'd0, out_valid}, 64'd0);
    cycle();
    check("lat_out_valid", {63'd0, out_valid}, 64'd1);
    check("lat_out_data", {30'd0, out_data}, 64'h1_3F80_0000);
    drain();

    // classification of individual words
    send(32'h80000000, 34'h0_8000_0000);
    send(32'h7F800000, 34'h2_0000_0000);
    send(32'h7FC00001, 34'h3_0000_0000);
    send(32'h80000001, 34'h0_8000_0000);
    send(32'h00000000, 34'h0_0000_0000);
    send(32'h7F7FFFFF, 34'h1_7F7F_FFFF);
    send(32'h00000001, 34'h0_0000_0000);
    send(32'hFF800000, 34'h2_8000_0000);
    drain();
`ifdef FCVT_STATS_EN
    check("dir_nan_count", {48'd0, nan_count}, 64'd1);
    check("dir_flush_count", {48'd0, flush_count}, 64'd2);
`endif

    // 8 words back-to-back with out_ready low for cycles 3-7
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 7);
      drive(idx < 8, (idx < 8) ? words[idx] : 32'h0, (idx < 8) ? exps[idx] : 34'h0, acc, rdy);
      check($sformatf("stream_in_ready_c%0d", cyc), {63'd0, rdy}, {63'd0, (cyc < 3 || cyc > 7)});
      if (acc) idx++;
    end
    check("stream_all_accepted", 64'(idx), 64'd8);
    drain();
`ifdef FCVT_STATS_EN
    check("stream_nan_count", {48'd0, nan_count}, 64'd3);
    check("stream_flush_count", {48'd0, flush_count}, 64'd3);
`endif

    // reset with two words in flight
    out_ready = 1'b0;
    drive(1'b1, 32'h7FC00000, 34'h3_0000_0000, acc, rdy);
    check("rst_inflight_acc0", {63'd0, acc}, 64'd1);
    drive(1'b1, 32'h80000001, 34'h0_8000_0000, acc, rdy);
    check("rst_inflight_acc1", {63'd0, acc}, 64'd1);
    check("rst_inflight_out_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    cycle();
    rst = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_data", {30'd0, out_data}, 64'd0);
`ifdef FCVT_STATS_EN
    check("midrst_nan_count", {48'd0, nan_count}, 64'd0);
    check("midrst_flush_count", {48'd0, flush_count}, 64'd0);
`endif
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(32'h40490FDB, 34'h1_4049_0FDB);
    drain();

`ifdef FCVT_STATS_EN
    // nan_count saturation
    out_ready = 1'b1;
    for (int i = 0; i < 65539; i++) begin
      drive(1'b1, 32'h7FC00000, 34'h3_0000_0000, acc, rdy);
    end
    drain();
    check("sat_nan_count", {48'd0, nan_count}, 64'h0000_0000_0000_FFFF);
    check("sat_flush_count", {48'd0, flush_count}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
